dma_loopback_ctrl: RTL

Cache-line DMA loopback engine sitting directly downstream of the MMIO memory map. It consumes the `go`, `rd_addr`, `wr_addr` and `size` values that software programs, streams `size` cache lines from `rd_addr` through an internal FIFO to `wr_addr`, and returns `done` to the memory map. Its memory-side ports are simple in-order request/response channels that the platform DMA adapter services.

---
 rtl/dma_loopback_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dma_loopback_ctrl.sv
// Cache-line DMA loopback: streams `size` lines from rd_addr through a FIFO to wr_addr.
// Optional cycle counter on `cycles` enabled by DMA_LOOPBACK_PERF_EN.
//
// state  | meaning
// IDLE   | waiting for go; request ports quiet
// RUN    | issuing reads/writes until all write completions are counted
// DONE   | done asserted; waits for go to drop
module dma_loopback_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17,
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic                  wr_rsp_valid,
    output logic [31:0]           cycles
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = SIZE_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(64);
    localparam logic [PTR_W+1:0]      DEPTH_L    = (PTR_W+2)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]        ONE_P      = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      size_q;
    logic [CNT_W-1:0]      reads_issued;
    logic [CNT_W-1:0]      writes_done;
    logic [CNT_W-1:0]      wr_done_nxt;
    logic [PTR_W:0]        outstanding;
    logic [PTR_W:0]        fifo_count;
    logic [PTR_W-1:0]      fifo_wr_ptr;
    logic [PTR_W-1:0]      fifo_rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  credit_ok;
    logic                  rd_hs;
    logic                  wr_hs;
    logic                  push;
    logic                  pop;
    logic                  start;

    // In-flight reads plus buffered lines never exceed the FIFO depth, so pushes never overflow.
    assign credit_ok    = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_L;
    assign rd_req_valid = (state == S_RUN) && (reads_issued < size_q) && credit_ok;
    assign wr_req_valid = (state == S_RUN) && (fifo_count != '0);
    assign done         = (state == S_DONE);
    assign rd_req_addr  = rd_addr_q;
    assign wr_req_addr  = wr_addr_q;
    assign wr_req_data  = fifo_mem[fifo_rd_ptr];

    assign rd_hs       = rd_req_valid && rd_req_ready;
    assign wr_hs       = wr_req_valid && wr_req_ready;
    assign push        = (state == S_RUN) && rd_rsp_valid;
    assign pop         = wr_hs;
    assign start       = (state == S_IDLE) && go && (size != '0);
    assign wr_done_nxt = writes_done + (wr_rsp_valid ? ONE_C : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            size_q       <= '0;
            reads_issued <= '0;
            writes_done  <= '0;
            outstanding  <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (size != '0) begin
                            state        <= S_RUN;
                            size_q       <= {1'b0, size};
                            rd_addr_q    <= rd_addr;
                            wr_addr_q    <= wr_addr;
                            reads_issued <= '0;
                            writes_done  <= '0;
                            outstanding  <= '0;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_hs) begin
                        rd_addr_q    <= rd_addr_q + LINE_BYTES;
                        reads_issued <= reads_issued + ONE_C;
                    end
                    if (wr_hs) begin
                        wr_addr_q <= wr_addr_q + LINE_BYTES;
                    end
                    if (rd_hs && !rd_rsp_valid) begin
                        outstanding <= outstanding + ONE_P;
                    end else if (!rd_hs && rd_rsp_valid) begin
                        outstanding <= outstanding - ONE_P;
                    end
                    writes_done <= wr_done_nxt;
                    // Compare against the next count so done rises one cycle after the last completion.
                    if (wr_done_nxt == size_q) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!go) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= rd_rsp_data;
                fifo_wr_ptr           <= fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE_P;
                2'b01:   fifo_count <= fifo_count - ONE_P;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef DMA_LOOPBACK_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if (start) begin
            cycles_q <= '0;
        end else if ((state == S_RUN) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = 32'd0;
`endif

endmodule
